// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
    parameter int WIDTH = 32
);
    logic             dmem_req;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [3:0]       dmem_be;
    logic [WIDTH-1:0] dmem_wdata;
    logic [WIDTH-1:0] dmem_rdata;
    logic             dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: issues word-aligned byte-enabled requests, stalls the core
// until completion, and sign/zero-extends load data for writeback.
module load_store_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  store_data,
    output logic [WIDTH-1:0]  load_data,
    output logic              stall,
    output logic              err,
    load_store_unit_if.master dmem
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] tmo_cnt;
    logic [1:0]    off_p1;
    logic [2:0]    f3_p1;
    logic          err_tmo_p1;
    logic          access, illegal, f3_ok;
    logic          stall_c, err_ill, go, hs, tmo;

    function automatic logic [3:0] lane_be(input logic we, input logic [2:0] f3,
                                           input logic [1:0] off);
        if (!we)
            return 4'b1111;
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] lane_wdata(input logic [2:0] f3,
                                                    input logic [WIDTH-1:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] load_ext(input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [WIDTH-1:0] rd);
        logic [WIDTH-1:0]        bsh, hsh;
        logic signed [7:0]       sb;
        logic signed [15:0]      sh;
        logic signed [WIDTH-1:0] r;
        bsh = rd >> {off, 3'b000};
        hsh = rd >> {off[1], 4'b0000};
        sb  = bsh[7:0];
        sh  = hsh[15:0];
        case (f3)
            3'b000:  r = WIDTH'(sb);
            3'b001:  r = WIDTH'(sh);
            3'b100:  r = {{(WIDTH-8){1'b0}}, bsh[7:0]};
            3'b101:  r = {{(WIDTH-16){1'b0}}, hsh[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    always_comb begin
        access  = mem_read | mem_write;
        f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
        illegal = (mem_read & mem_write) | ~f3_ok | (mem_write & funct3[2]) |
                  ((funct3[1:0] == 2'b01) & addr[0]) |
                  ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        err_ill   = 1'b0;
        go        = 1'b0;
        hs        = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        err_ill = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        go        = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem.dmem_req && dmem.dmem_ready) begin
                    hs        = 1'b1;
                    state_nxt = DONE;
                end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset forces the core-facing controls low even while it is held.
    assign stall = stall_c & ~rst;
    assign err   = (err_ill | err_tmo_p1) & ~rst;

    // Request stage: captured on IDLE->BUSY, completed on ready or watchdog expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            err_tmo_p1      <= 1'b0;
            off_p1          <= '0;
            f3_p1           <= '0;
            load_data       <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
        end else begin
            state      <= state_nxt;
            err_tmo_p1 <= tmo;
            if (go) begin
                tmo_cnt         <= '0;
                off_p1          <= addr[1:0];
                f3_p1           <= funct3;
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= mem_write;
                dmem.dmem_addr  <= {addr[WIDTH-1:2], 2'b00};
                dmem.dmem_be    <= lane_be(mem_write, funct3, addr[1:0]);
                dmem.dmem_wdata <= lane_wdata(funct3, store_data);
            end
            if (hs) begin
                if (!dmem.dmem_we)
                    load_data <= load_ext(f3_p1, off_p1, dmem.dmem_rdata);
                dmem.dmem_req <= 1'b0;
                dmem.dmem_we  <= 1'b0;
            end else if (tmo) begin
                load_data     <= '0;
                dmem.dmem_req <= 1'b0;
                dmem.dmem_we  <= 1'b0;
            end else if (state == BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory slave.
module tb_load_store_unit;
    localparam int TMO   = 4;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, load_data;
    logic        stall, err;

    load_store_unit_if #(.WIDTH(32)) bus ();

    load_store_unit #(.WIDTH(32), .TIMEOUT(TMO)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .stall      (stall),
        .err        (err),
        .dmem       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          tmo;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          rdy_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] model_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference rules, expressed arithmetically on byte offsets.
    function automatic bit legal(input bit r, input bit w, input int f3, input int a);
        if (r && w) return 0;
        if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 0;
        if (w && f3 >= 4) return 0;
        if ((f3 % 4) == 1 && (a % 2) != 0) return 0;
        if (f3 == 2 && a != 0) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] ref_be(input bit w, input int f3, input int a);
        if (!w) return 4'hF;
        if (f3 == 0) return 4'(1 << a);
        if (f3 == 1) return 4'(3 << ((a / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] d);
        if (f3 == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3 == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int a, input logic [31:0] rd);
        longint b, h;
        b = longint'((rd >> (8 * a)) & 32'hFF);
        h = longint'((rd >> (16 * (a / 2))) & 32'hFFFF);
        case (f3)
            0: return 32'((b >= 128) ? b - 256 : b);
            1: return 32'((h >= 32768) ? h - 65536 : h);
            4: return 32'(b);
            5: return 32'(h);
            default: return rd;
        endcase
    endfunction

    // Memory slave: ready after rdy_delay BUSY cycles, random noise when idle.
    always @(posedge clk) begin
        #1;
        if (bus.dmem_req === 1'b1) begin
            bus.dmem_ready = (wait_cnt == rdy_delay);
            wait_cnt++;
        end else begin
            wait_cnt = 0;
            bus.dmem_ready = ($urandom_range(3) == 0);
        end
        bus.dmem_rdata = mem_rdata;
    end

    // Monitor: pops the scoreboard on each handshake or error pulse.
    bit          pend = 0;
    logic [31:0] pend_ld;
    exp_t        me;
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
        end else begin
            if (pend) begin
                chk("done_load_data", load_data, pend_ld);
                chk("done_stall", stall, 0);
                chk("done_err", err, 0);
                pend = 0;
            end
            if (bus.dmem_req) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req actual=1 expected=0");
                end else begin
                    me = sbq[0];
                    chk("req_addr", bus.dmem_addr, me.addr);
                    chk("req_be", bus.dmem_be, me.be);
                    chk("req_we", bus.dmem_we, me.we);
                    if (me.we) chk("req_wdata", bus.dmem_wdata, me.wdata);
                    chk("busy_stall", stall, 1);
                    if (bus.dmem_ready) begin
                        void'(sbq.pop_front());
                        pend    = 1;
                        pend_ld = me.ld;
                    end
                end
            end else if (err) begin
                checks++;
                if (sbq.size() == 0 || !sbq[0].is_err) begin
                    errors++;
                    $display("FAIL unexpected_err actual=1 expected=0");
                end else begin
                    me = sbq.pop_front();
                    chk("err_stall", stall, 0);
                    if (me.tmo) chk("tmo_load_data", load_data, 32'h0);
                end
            end
        end
    end

    task automatic do_access(input bit r, input bit w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rd, input int dly);
        exp_t e;
        bit   ok;
        int   n;
        int   exp_n;
        ok = legal(r, w, int'(f3), int'(a[1:0]));
        rdy_delay = dly;
        mem_rdata = rd;
        @(posedge clk); #2;
        mem_read = r; mem_write = w; funct3 = f3; addr = a; store_data = d;
        e.tmo    = ok && (dly >= TMO);
        e.is_err = !ok || e.tmo;
        e.we     = w;
        e.addr   = a & 32'hFFFF_FFFC;
        e.be     = ref_be(w, int'(f3), int'(a[1:0]));
        e.wdata  = ref_wdata(int'(f3), d);
        if (!ok)        e.ld = model_ld;
        else if (e.tmo) e.ld = 32'h0;
        else if (w)     e.ld = model_ld;
        else            e.ld = ref_load(int'(f3), int'(a[1:0]), rd);
        model_ld = e.ld;
        sbq.push_back(e);
        @(negedge clk);
        chk("issue_stall", stall, 32'(ok));
        @(posedge clk); #2;
        mem_read = 0; mem_write = 0;
        if (!ok) begin
            @(negedge clk);
            chk("illegal_no_req", bus.dmem_req, 0);
            return;
        end
        n = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        exp_n = e.tmo ? 1 + TMO : 2 + dly;
        chk("stall_cycles", n, exp_n);
    endtask

    task automatic reset_mid_busy();
        exp_t e;
        rdy_delay = NEVER;
        @(posedge clk); #2;
        mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h0000_0100;
        e = '{is_err: 1, tmo: 1, we: 0, addr: 32'h100, be: 4'hF, wdata: 32'h0, ld: 32'h0};
        sbq.push_back(e);
        @(posedge clk); #2;
        mem_read = 0;
        @(posedge clk); #2;
        rst = 1; #1;
        chk("rst_mid_req", bus.dmem_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_load_data", load_data, 0);
        chk("rst_mid_be", bus.dmem_be, 0);
        sbq.delete();
        model_ld = 32'h0;
        @(posedge clk); #2;
        rst = 0;
    endtask

    initial begin
        bit r, w;
        int dly;
        rst = 1; mem_read = 1; mem_write = 0; funct3 = 3'b011;
        addr = 32'h1; store_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_err", err, 0);
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_we", bus.dmem_we, 0);
        chk("rst_addr", bus.dmem_addr, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_load_data", load_data, 0);
        mem_read = 0;
        @(posedge clk); #2;
        rst = 0;

        do_access(0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0);
        do_access(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0);
        do_access(0, 1, 3'b001, 32'h0000_1002, 32'h0000_1234, 32'h0, 1);
        do_access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0);
        do_access(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_7F01, 0);
        do_access(1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_7F01, 0);
        do_access(1, 0, 3'b101, 32'h0000_1000, 32'h0, 32'h80FF_7F01, 0);
        do_access(0, 1, 3'b010, 32'h0000_2000, 32'h1111_2222, 32'h0, 2);
        do_access(1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0);
        do_access(1, 0, 3'b001, 32'h0000_1001, 32'h0, 32'h0, 0);
        do_access(1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0);
        do_access(0, 1, 3'b100, 32'h0000_1000, 32'h0, 32'h0, 0);
        do_access(1, 1, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 0);
        do_access(1, 0, 3'b010, 32'h0000_3008, 32'h0, 32'hCAFE_F00D, 3);
        do_access(1, 0, 3'b010, 32'h0000_300C, 32'h0, 32'h1234_5678, NEVER);
        reset_mid_busy();
        do_access(1, 0, 3'b000, 32'h0000_4001, 32'h0, 32'h0000_8000, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(1);
            w = !r;
            if ($urandom_range(15) == 0) begin r = 1; w = 1; end
            dly = ($urandom_range(19) == 0) ? NEVER : int'($urandom_range(3));
            do_access(r, w, 3'($urandom_range(7)), $urandom, $urandom, $urandom, dly);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
